// File: rtl/alu_wide_sequencer.sv
// rtl/alu_wide_sequencer.sv - 32-bit ADD/SUB/ADC sequencer chaining two 16-bit ALU passes
module alu_wide_sequencer (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        ReqValid,
   output logic        ReqReady,
   input  logic [1:0]  ReqOp,
   input  logic [31:0] ReqA,
   input  logic [31:0] ReqB,
   output logic [15:0] AluA,
   output logic [15:0] AluB,
   output logic [4:0]  AluFunSel,
   output logic        AluWF,
   input  logic [15:0] AluOut,
   input  logic [3:0]  AluFlags,
   output logic        RspValid,
   input  logic        RspReady,
   output logic [31:0] RspData,
   output logic [3:0]  RspFlags
);

   localparam logic [2:0] StIdle = 3'd0;
   localparam logic [2:0] StLo   = 3'd1;
   localparam logic [2:0] StHi   = 3'd2;
   localparam logic [2:0] StCap  = 3'd3;
   localparam logic [2:0] StResp = 3'd4;

   localparam logic [4:0] FunAdd = 5'b10100;
   localparam logic [4:0] FunAdc = 5'b10101;
   localparam logic [4:0] FunSub = 5'b10110;

   localparam logic [1:0] OpSub = 2'b01;
   localparam logic [1:0] OpAdc = 2'b10;

   logic [2:0]  state;
   logic [31:0] opA;
   logic [31:0] opB;
   logic [1:0]  op;
   logic [15:0] loRes;
   logic [15:0] hiRes;
   logic        loZero;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state    <= StIdle;
         opA      <= '0;
         opB      <= '0;
         op       <= '0;
         loRes    <= '0;
         hiRes    <= '0;
         loZero   <= 1'b0;
         RspData  <= '0;
         RspFlags <= '0;
      end else begin
         case (state)
            StIdle: begin
               if (ReqValid) begin
                  opA   <= ReqA;
                  opB   <= ReqB;
                  op    <= ReqOp;
                  state <= StLo;
               end
            end
            StLo: begin
               loRes  <= AluOut;
               loZero <= (AluOut == 16'h0000);
               state  <= StHi;
            end
            StHi: begin
               hiRes <= AluOut;
               state <= StCap;
            end
            StCap: begin
               // C/N/O belong to the high pass; Z must cover all 32 bits
               RspData  <= {hiRes, loRes};
               RspFlags <= {loZero & AluFlags[3], AluFlags[2:0]};
               state    <= StResp;
            end
            StResp: begin
               if (RspReady) state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

   always_comb begin
      AluA      = '0;
      AluB      = '0;
      AluFunSel = '0;
      AluWF     = 1'b0;
      case (state)
         StLo: begin
            AluA  = opA[15:0];
            AluB  = opB[15:0];
            AluWF = 1'b1;
            if (op == OpSub)      AluFunSel = FunSub;
            else if (op == OpAdc) AluFunSel = FunAdc;
            else                  AluFunSel = FunAdd;
         end
         StHi: begin
            // Subtract carry means "no borrow", so A + ~B + C continues the chain
            AluA      = opA[31:16];
            AluB      = (op == OpSub) ? ~opB[31:16] : opB[31:16];
            AluFunSel = FunAdc;
            AluWF     = 1'b1;
         end
         default: ;
      endcase
   end

   assign ReqReady = (state == StIdle);
   assign RspValid = (state == StResp);

endmodule

// File: doc/alu_wide_sequencer.md
# alu_wide_sequencer

Multi-cycle front-end for the 16-bit ArithmeticLogicUnit that executes 32-bit ADD, SUB and ADC requests as two chained 16-bit ALU passes. It sits directly upstream of the ALU, driving its A/B/FunSel/WF inputs. It also sits downstream of the ALU, consuming ALUOut and FlagsOut to assemble a registered 32-bit result and merged {Z,C,N,O} flags. Requests and responses use valid/ready handshakes.

## Interface
No parameters; all widths are fixed by the ALU.
- Clock  in  1  system clock; the ALU shares it.
- Reset  in  1  synchronous, active-high.
- ReqValid  in  1  request offered.
- ReqReady  out  1  request accepted on an edge where ReqValid and ReqReady are both 1.
- ReqOp  in  2  00 ADD, 01 SUB, 10 ADC (32-bit add using the ALU's current C as carry-in), 11 reserved (executed as ADD).
- ReqA  in  32  operand A.
- ReqB  in  32  operand B.
- AluA  out  16  to ALU A.
- AluB  out  16  to ALU B.
- AluFunSel  out  5  to ALU FunSel.
- AluWF  out  1  to ALU WF.
- AluOut  in  16  from ALU ALUOut; combinational in A, B, FunSel and the ALU's current flags.
- AluFlags  in  4  from ALU FlagsOut, ordered {Z,C,N,O}; updated on a Clock edge when WF=1.
- RspValid  out  1  result available.
- RspReady  in  1  consumer accepts.
- RspData  out  32  result.
- RspFlags  out  4  {Z,C,N,O} of the 32-bit operation.

## Operation
- States: IDLE, LO, HI, CAP, RESP.
- **IDLE**
  - ReqReady=1; ALU outputs are all 0 (AluWF=0).
  - On a request handshake: latch ReqA, ReqB and ReqOp; go to LO.
- **LO** (low pass)
  - AluA=A[15:0]; AluB=B[15:0]; AluWF=1.
  - AluFunSel: 10100 for ADD/reserved, 10110 for SUB, 10101 for ADC.
  - At the edge: latch lo_res=AluOut and lo_zero=(AluOut==0); go to HI.
- **HI** (high pass)
  - AluA=A[31:16]; AluFunSel=10101 (A+B+C); AluWF=1.
  - AluB=B[31:16] for ADD/ADC/reserved, ~B[31:16] for SUB.
  - SUB uses the ALU subtract carry convention: C=1 means no borrow. The high pass therefore computes A_hi + ~B_hi + C, which is a correct 32-bit borrow chain.
  - At the edge: latch hi_res=AluOut; go to CAP.
- **CAP**
  - AluWF=0, so the ALU flags hold.
  - At the edge: RspData={hi_res, lo_res}; RspFlags={lo_zero & AluFlags[3], AluFlags[2:0]}; go to RESP.
  - C, N and O come from the high pass. Z must be the full 32-bit zero, which is why lo_zero is ANDed in.
- **RESP**
  - RspValid=1; AluWF=0.
  - RspData and RspFlags are held stable while RspReady=0.
  - On the response handshake: go to IDLE.
- ReqReady=0 in every state except IDLE.
- ReqA/ReqB/ReqOp changes after acceptance have no effect on the operation in flight.
- This block never resets or forces the ALU flag register; ALU flag state at the start of ADC is used as-is.

## Timing
- Reset values: state IDLE, ReqReady=1, RspValid=0, RspData=0, RspFlags=0, AluA=0, AluB=0, AluFunSel=0, AluWF=0.
- Latency: request accepted at edge n → LO in cycle n+1, HI in n+2, CAP in n+3, RspValid=1 from cycle n+4.
- Best-case throughput: one operation per 5 cycles. The RESP handshake edge returns to IDLE, and the next request is accepted at the following edge.
- AluWF=1 in exactly two consecutive cycles per operation (LO, HI); it is 0 in all other states.
- Reset asserted in any state: at that edge go to IDLE with all outputs at their reset values. Any in-flight operation is dropped with no response. ALU flags may already reflect a partial pass.
- ReqValid while not in IDLE is ignored (ReqReady=0); the requester must hold it.

## Test plan
- ADD 0x0001FFFF + 0x00000001 → RspData 0x00020000, RspFlags Z0 C0 N0 O0. Low pass drives FunSel 10100; high pass drives 10101.
- ADD 0xFFFFFFFF + 0x00000001 → RspData 0x00000000, Z1 C1 N0 O0, exercising the lo_zero merge. Repeat with 0x0000FFFF + 0x00000001 → 0x00010000 with Z0.
- SUB 0x00000000 − 0x00000001 → 0xFFFFFFFF, Z0 C0 N1 O0. SUB 0x80000000 − 0x00000001 → 0x7FFFFFFF, Z0 C1 N0 O1. In both, AluB in HI = ~B_hi (0xFFFF).
- ADC: first run ADD 0xFFFFFFFF + 1 to leave ALU C=1, then ADC 0x00000000 + 0x00000000 → 0x00000001, Z0 C0 N0 O0.
- Handshake: accept a request, hold RspReady=0 for 3 cycles; RspValid/RspData stay stable and ReqReady stays 0. Release RspReady: after that handshake edge ReqReady is 1 in IDLE, and a request is accepted at the next edge. First RspValid arrives exactly 4 cycles after the accepting edge.
- Assert Reset while in HI → next cycle IDLE, ReqReady=1, RspValid=0, AluWF=0, RspData=0. A subsequent ADD 1 + 2 → 0x00000003, Z0 C0 N0 O0.
